mux_sweep_sequencer: RTL and testbench

//   Self-test sequencer for the 4-to-1 select mux (F from A,B under select C,D).
//   On a start pulse it latches A/B operands, sweeps select {C,D} through 00,01,10,11,

---
 rtl/mux_sweep_sequencer.sv | 143 ++++++++++++++
 tb/tb_mux_sweep_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mux_sweep_sequencer.sv
// Self-test sequencer for a 4-to-1 select mux. It latches the A/B operands,
// sweeps the select code 00..11, samples F after a settle window and flags mismatches.
`timescale 1ns/1ps
module mux_sweep_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       a_in,
    input  logic       b_in,
    input  logic       f_in,
    output logic       mux_a,
    output logic       mux_b,
    output logic       mux_c,
    output logic       mux_d,
    output logic       busy,
    output logic       done,
    output logic [3:0] result,
    output logic [3:0] mismatch,
    output logic       error
);

    localparam int SETTLE = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int CW     = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [1:0]    code_reg, code_next;
    logic          a_reg, a_next;
    logic          b_reg, b_next;
    logic [3:0]    result_reg, result_next;
    logic [3:0]    mismatch_reg, mismatch_next;
    logic          error_reg, error_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          expected;

    // Reference function of the mux for the latched operands.
    always_comb begin
        expected = 1'b0;
        case (code_reg)
            2'b00:   expected = ~a_reg;
            2'b01:   expected = b_reg;
            2'b10:   expected = ~b_reg;
            default: expected = 1'b0;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        code_next     = code_reg;
        a_next        = a_reg;
        b_next        = b_reg;
        result_next   = result_reg;
        mismatch_next = mismatch_reg;
        error_next    = error_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next        = a_in;
                    b_next        = b_in;
                    code_next     = 2'b00;
                    cnt_next      = '0;
                    result_next   = 4'b0000;
                    mismatch_next = 4'b0000;
                    error_next    = 1'b0;
                    busy_next     = 1'b1;
                    state_next    = DRIVE;
                end
            end
            DRIVE: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CW'(SETTLE - 1)) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                result_next[code_reg]   = f_in;
                // Case inequality so an undriven or unknown F is reported as a fault.
                mismatch_next[code_reg] = (f_in !== expected);
                if (code_reg == 2'b11) begin
                    error_next = |mismatch_next;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = DONE;
                end else begin
                    code_next  = code_reg + 2'b01;
                    cnt_next   = '0;
                    state_next = DRIVE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            code_reg     <= 2'b00;
            a_reg        <= 1'b0;
            b_reg        <= 1'b0;
            result_reg   <= 4'b0000;
            mismatch_reg <= 4'b0000;
            error_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            code_reg     <= code_next;
            a_reg        <= a_next;
            b_reg        <= b_next;
            result_reg   <= result_next;
            mismatch_reg <= mismatch_next;
            error_reg    <= error_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    assign mux_a    = a_reg;
    assign mux_b    = b_reg;
    assign mux_c    = code_reg[1];
    assign mux_d    = code_reg[0];
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign result   = result_reg;
    assign mismatch = mismatch_reg;
    assign error    = error_reg;

endmodule

// File: tb/tb_mux_sweep_sequencer.sv
// Directed bench for mux_sweep_sequencer: ideal and stuck mux models, start
// filtering, mid-sweep reset, and a second instance with a longer settle window.
`timescale 1ns/1ps
module tb_mux_sweep_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, a_in, b_in, stuck, sel;
    logic f1, f2;
    logic mux_a1, mux_b1, mux_c1, mux_d1, busy1, done1, error1;
    logic mux_a2, mux_b2, mux_c2, mux_d2, busy2, done2, error2;
    logic [3:0] result1, mismatch1, result2, mismatch2;

    int checks = 0;
    int errors = 0;

    // Behaviour of the mux under test: {C,D} 00 -> ~A, 01 -> B, 10 -> ~B, 11 -> 0.
    function automatic logic mux_model(input logic a, input logic b, input logic c, input logic d);
        case ({c, d})
            2'b00:   return ~a;
            2'b01:   return b;
            2'b10:   return ~b;
            default: return 1'b0;
        endcase
    endfunction

    assign f1 = stuck ? 1'b1 : mux_model(mux_a1, mux_b1, mux_c1, mux_d1);
    assign f2 = stuck ? 1'b1 : mux_model(mux_a2, mux_b2, mux_c2, mux_d2);

    mux_sweep_sequencer #(.SETTLE_CYCLES(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start & ~sel), .a_in(a_in), .b_in(b_in),
        .f_in(f1), .mux_a(mux_a1), .mux_b(mux_b1), .mux_c(mux_c1), .mux_d(mux_d1),
        .busy(busy1), .done(done1), .result(result1), .mismatch(mismatch1), .error(error1)
    );

    mux_sweep_sequencer #(.SETTLE_CYCLES(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start & sel), .a_in(a_in), .b_in(b_in),
        .f_in(f2), .mux_a(mux_a2), .mux_b(mux_b2), .mux_c(mux_c2), .mux_d(mux_d2),
        .busy(busy2), .done(done2), .result(result2), .mismatch(mismatch2), .error(error2)
    );

    logic       o_a, o_b, o_c, o_d, o_busy, o_done, o_error;
    logic [3:0] o_result, o_mismatch;
    assign o_a        = sel ? mux_a2    : mux_a1;
    assign o_b        = sel ? mux_b2    : mux_b1;
    assign o_c        = sel ? mux_c2    : mux_c1;
    assign o_d        = sel ? mux_d2    : mux_d1;
    assign o_busy     = sel ? busy2     : busy1;
    assign o_done     = sel ? done2     : done1;
    assign o_error    = sel ? error2    : error1;
    assign o_result   = sel ? result2   : result1;
    assign o_mismatch = sel ? mismatch2 : mismatch1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {o_a, o_b, o_c, o_d, o_busy, o_done, o_error, o_result, o_mismatch}, 32'd0);
    endtask

    // Runs one sweep: start presented in cycle 0, optional re-pulses of start and
    // a toggle of a_in at the given cycles, then checks timing and verdict.
    task automatic sweep(input string tag, input int settle, input logic a, input logic b,
                         input int rep1, input int rep2, input int tog,
                         input logic [3:0] exp_res, input logic [3:0] exp_mis, input logic exp_err);
        int done_cyc;
        int done_cnt;
        int span;
        span     = 4 * (settle + 1);
        done_cyc = -1;
        done_cnt = 0;
        @(posedge clk); #1;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        for (int cyc = 1; cyc <= span + 6; cyc++) begin
            @(posedge clk); #1;
            start = (cyc == rep1) || (cyc == rep2);
            if (cyc == tog) a_in = ~a_in;
            @(negedge clk);
            if (cyc <= span) begin
                check({tag, "_busy"}, 32'(o_busy), 32'd1);
                check({tag, "_code"}, 32'({o_c, o_d}), 32'((cyc - 1) / (settle + 1)));
                check({tag, "_mux_ab"}, 32'({o_a, o_b}), 32'({a, b}));
            end
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'(span + 1));
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_result"}, 32'(o_result), 32'(exp_res));
        check({tag, "_mismatch"}, 32'(o_mismatch), 32'(exp_mis));
        check({tag, "_error"}, 32'(o_error), 32'(exp_err));
        check({tag, "_idle"}, 32'({o_busy, o_c, o_d}), 32'b011);
        $display("sweep %s a=%0b b=%0b done@%0d result=%b mismatch=%b error=%0b",
                 tag, a, b, done_cyc, o_result, o_mismatch, o_error);
    endtask

    initial begin
        int done_cyc;
        reset = 1'b1;
        start = 1'b1;
        a_in  = 1'b1;
        b_in  = 1'b1;
        stuck = 1'b0;
        sel   = 1'b0;

        // Reset held two cycles with start asserted.
        @(posedge clk); @(negedge clk);
        check_all_zero("reset_c1");
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_all_zero("reset_c2");
        @(posedge clk); @(negedge clk);
        check("reset_start_ignored", 32'(o_busy), 32'd0);
        $display("reset released busy=%0b", o_busy);

        sweep("ideal_a1b0", 2, 1'b1, 1'b0, 0, 0, 0, 4'b0100, 4'b0000, 1'b0);
        sweep("ideal_a0b1", 2, 1'b0, 1'b1, 0, 0, 0, 4'b0011, 4'b0000, 1'b0);
        stuck = 1'b1;
        sweep("stuck1_a1b0", 2, 1'b1, 1'b0, 0, 0, 0, 4'b1111, 4'b1011, 1'b1);
        stuck = 1'b0;
        sweep("restart_filter", 2, 1'b1, 1'b0, 3, 13, 5, 4'b0100, 4'b0000, 1'b0);

        // Reset asserted in cycle 6 of a sweep, new start in cycle 9.
        @(posedge clk); #1;
        a_in  = 1'b1;
        b_in  = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(negedge clk);
        check("midreset_before", 32'({o_busy, o_a, o_c, o_d}), 32'b1101);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("midreset_c7");
        @(posedge clk); #1;
        @(posedge clk); #1;
        start    = 1'b1;
        done_cyc = -1;
        for (int cyc = 10; cyc <= 30; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (o_done && done_cyc < 0) done_cyc = cyc;
        end
        check("midreset_done_cycle", 32'(done_cyc), 32'd22);
        check("midreset_result", 32'({o_result, o_mismatch, o_error}), 32'b0100_0000_0);
        $display("sweep midreset done@%0d result=%b error=%0b", done_cyc, o_result, o_error);

        sel = 1'b1;
        sweep("settle4", 4, 1'b1, 1'b0, 0, 0, 0, 4'b0100, 4'b0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
